// File: rtl/cam_read_param_if.sv
// Camera byte bus and frame-buffer write port bundled together.
// The slave modport is the capture block's view, the master the surrounding system's.
interface cam_read_param_if #(
  parameter int ADDR_W = 15
);
  logic              vsync;
  logic              href;
  logic [7:0]        input_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;

  modport master (
    output vsync, href, input_data,
    input  mem_addr, mem_data, mem_we
  );

  modport slave (
    input  vsync, href, input_data,
    output mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/cam_read_param.sv
// Camera capture: frames a byte stream into RGB332/gray pixels and writes them,
// optionally decimated by 2, to a linear frame buffer.
module cam_read_param #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int DECIM  = 1,
  parameter int ADDR_W = 15
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      mode,
  cam_read_param_if.slave cam,
  output logic            frame_done,
  output logic            busy,
  output logic            line_err,
  output logic            frame_err,
  output logic [7:0]      frame_cnt
);

  localparam int SH    = (DECIM == 2) ? 1 : 0;
  localparam int H_OUT = H_RES / DECIM;
  localparam int CW    = $clog2(H_RES + 1);
  localparam int LW    = $clog2(V_RES + 2);

  typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_ACT, CAPTURE} state_t;

  state_t            state;
  logic              vsync_d;
  logic              href_d;
  logic              phase;
  logic [7:0]        b0;
  logic [7:0]        pix_val;
  logic [CW-1:0]     col_cnt;
  logic [LW-1:0]     line_cnt;
  logic              vs_rise;
  logic              vs_fall;
  logic              pix_done;
  logic              keep;
  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;

  assign vs_rise  = cam.vsync & ~vsync_d;
  assign vs_fall  = ~cam.vsync & vsync_d;
  assign pix_done = cam.href & ((mode == 2'b11) | phase);
  assign keep     = (SH == 0) || (!col_cnt[0] && !line_cnt[0]);
  assign wr_ok    = (state == CAPTURE) && pix_done && (col_cnt < CW'(H_RES)) &&
                    (line_cnt < LW'(V_RES)) && keep;
  assign wr_addr  = ADDR_W'(32'(line_cnt >> SH) * H_OUT + 32'(col_cnt >> SH));

  always_comb begin
    pix_val = 8'h00;
    case (mode)
      2'b00:   pix_val = {b0[7:5], b0[2:0], cam.input_data[4:3]};
      2'b01:   pix_val = {b0[3:1], cam.input_data[7:5], cam.input_data[3:2]};
      2'b10:   pix_val = b0;
      default: pix_val = cam.input_data;
    endcase
  end

  // busy is kept in step with state so it is high exactly when state != IDLE
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      vsync_d    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      vsync_d    <= cam.vsync;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= WAIT_VS;
            busy  <= 1'b1;
          end
        end
        WAIT_VS: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_rise) begin
            state <= WAIT_ACT;
          end
        end
        WAIT_ACT: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_fall) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            if (line_cnt != LW'(V_RES)) frame_err <= 1'b1;
            if (enable) begin
              state <= WAIT_ACT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Counters saturate one past their limit so overruns stay detectable
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      href_d       <= 1'b0;
      phase        <= 1'b0;
      b0           <= 8'h00;
      col_cnt      <= '0;
      line_cnt     <= '0;
      line_err     <= 1'b0;
      cam.mem_we   <= 1'b0;
      cam.mem_addr <= '0;
      cam.mem_data <= 8'h00;
    end else begin
      href_d     <= cam.href;
      phase      <= cam.href ? ~phase : 1'b0;
      cam.mem_we <= wr_ok;
      if (cam.href && !phase) b0 <= cam.input_data;
      if (wr_ok) begin
        cam.mem_addr <= wr_addr;
        cam.mem_data <= pix_val;
      end
      if (state == WAIT_ACT && vs_fall) begin
        col_cnt  <= '0;
        line_cnt <= '0;
      end else if (state == CAPTURE) begin
        if (!cam.href) begin
          col_cnt <= '0;
        end else if (pix_done) begin
          if (col_cnt == CW'(H_RES)) line_err <= 1'b1;
          else                       col_cnt  <= col_cnt + 1'b1;
        end
        if (href_d && !cam.href && line_cnt != LW'(V_RES + 1))
          line_cnt <= line_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_read_param.sv
// Two capture instances (full-res 4x2 and decimated 4x4) share one camera stream;
// a reference model queues expected writes/frames and a monitor pops and compares.
module tb_cam_read_param;

  typedef struct {
    int cnt;
    bit ferr;
    bit lerr;
  } fexp_t;

  logic       pclk   = 1'b0;
  logic       rst    = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode   = 2'b00;
  logic       vsync  = 1'b0;
  logic       href   = 1'b0;
  logic [7:0] din    = 8'h00;

  logic       fd_a, busy_a, lerr_a, ferr_a;
  logic       fd_b, busy_b, lerr_b, ferr_b;
  logic [7:0] fcnt_a, fcnt_b;

  int    tests = 0;
  int    fails = 0;
  int    wq [2][$];
  fexp_t fq [2][$];
  int    wr_exp  [2];
  int    wr_seen [2];
  int    exp_cnt;
  bit    exp_lerr;
  bit    exp_ferr_a;
  bit    exp_ferr_b;

  logic [7:0] fb  [0:7][0:15];
  int         len [0:7];

  always #5 pclk = ~pclk;

  cam_read_param_if #(.ADDR_W(4)) ifa ();
  cam_read_param_if #(.ADDR_W(4)) ifb ();

  assign ifa.vsync      = vsync;
  assign ifa.href       = href;
  assign ifa.input_data = din;
  assign ifb.vsync      = vsync;
  assign ifb.href       = href;
  assign ifb.input_data = din;

  cam_read_param #(.H_RES(4), .V_RES(2), .DECIM(1), .ADDR_W(4)) dut_a (
    .pclk(pclk), .rst(rst), .enable(enable), .mode(mode), .cam(ifa),
    .frame_done(fd_a), .busy(busy_a), .line_err(lerr_a), .frame_err(ferr_a),
    .frame_cnt(fcnt_a)
  );

  cam_read_param #(.H_RES(4), .V_RES(4), .DECIM(2), .ADDR_W(4)) dut_b (
    .pclk(pclk), .rst(rst), .enable(enable), .mode(mode), .cam(ifb),
    .frame_done(fd_b), .busy(busy_b), .line_err(lerr_b), .frame_err(ferr_b),
    .frame_cnt(fcnt_b)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Pixel value from the byte-to-colour rules, written with plain arithmetic
  function automatic int ref_pixel(input int md, input int l, input int p);
    int b0, b1;
    if (md == 3) return int'(fb[l][p]);
    b0 = int'(fb[l][2*p]);
    b1 = int'(fb[l][2*p+1]);
    case (md)
      0:       return (b0 / 32) * 32 + (b0 % 8) * 4 + (b1 / 8) % 4;
      1:       return ((b0 / 2) % 8) * 32 + (b1 / 32) * 4 + (b1 / 4) % 4;
      default: return b0;
    endcase
  endfunction

  task automatic model_frame(input int nl, input int md);
    int    v;
    fexp_t e;
    for (int l = 0; l < nl; l++) begin
      if (len[l] > 4) exp_lerr = 1'b1;
      for (int p = 0; p < len[l]; p++) begin
        v = ref_pixel(md, l, p);
        if (p < 4 && l < 2) begin
          wq[0].push_back((l * 4 + p) * 256 + v);
          wr_exp[0]++;
        end
        if (p < 4 && l < 4 && p % 2 == 0 && l % 2 == 0) begin
          wq[1].push_back(((l / 2) * 2 + p / 2) * 256 + v);
          wr_exp[1]++;
        end
      end
    end
    if (nl != 2) exp_ferr_a = 1'b1;
    if (nl != 4) exp_ferr_b = 1'b1;
    exp_cnt = (exp_cnt + 1) % 256;
    e.cnt  = exp_cnt;
    e.lerr = exp_lerr;
    e.ferr = exp_ferr_a;
    fq[0].push_back(e);
    e.ferr = exp_ferr_b;
    fq[1].push_back(e);
  endtask

  // One frame: vsync falls, nl lines of pixels, then vsync rises to close it
  task automatic apply_stimulus(input int nl, input int md, input int plen, input int pat,
                                input bit captured, input bit drop_en);
    int nb;
    mode = 2'(md);
    for (int l = 0; l < nl; l++) begin
      len[l] = (plen > 0) ? plen : int'($urandom_range(1, 6));
      for (int k = 0; k < 16; k++) begin
        case (pat)
          1:       fb[l][k] = (k % 2 == 0) ? 8'hF8 : 8'h1F;
          2:       fb[l][k] = (k % 2 == 0) ? 8'h55 : 8'h80;
          default: fb[l][k] = 8'($urandom);
        endcase
      end
    end
    if (captured) model_frame(nl, md);
    vsync = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < nl; l++) begin
      nb = (md == 3) ? len[l] : 2 * len[l];
      for (int k = 0; k < nb; k++) begin
        href = 1'b1;
        din  = fb[l][k];
        tick();
      end
      href = 1'b0;
      din  = 8'h00;
      repeat (3) tick();
      if (drop_en && l == 0) enable = 1'b0;
    end
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, "_we_a"},   ifa.mem_we,   0);
    check_output({tag, "_addr_a"}, ifa.mem_addr, 0);
    check_output({tag, "_data_a"}, ifa.mem_data, 0);
    check_output({tag, "_fd_a"},   fd_a,         0);
    check_output({tag, "_busy_a"}, busy_a,       0);
    check_output({tag, "_lerr_a"}, lerr_a,       0);
    check_output({tag, "_ferr_a"}, ferr_a,       0);
    check_output({tag, "_fcnt_a"}, fcnt_a,       0);
    check_output({tag, "_we_b"},   ifb.mem_we,   0);
    check_output({tag, "_addr_b"}, ifb.mem_addr, 0);
    check_output({tag, "_data_b"}, ifb.mem_data, 0);
    check_output({tag, "_fd_b"},   fd_b,         0);
    check_output({tag, "_busy_b"}, busy_b,       0);
    check_output({tag, "_lerr_b"}, lerr_b,       0);
    check_output({tag, "_ferr_b"}, ferr_b,       0);
    check_output({tag, "_fcnt_b"}, fcnt_b,       0);
  endtask

  task automatic on_write(input int d, input int act);
    string nm;
    nm = (d == 0) ? "write_a" : "write_b";
    wr_seen[d]++;
    if (wq[d].size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: unexpected write addr/data %0h, expected none", nm, act);
    end else begin
      check_output(nm, act, wq[d].pop_front());
    end
  endtask

  task automatic on_frame(input int d, input int cnt, input bit ferr, input bit lerr);
    fexp_t e;
    string sfx;
    sfx = (d == 0) ? "_a" : "_b";
    if (fq[d].size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL frame_done%s: unexpected pulse, frame_cnt %0d", sfx, cnt);
    end else begin
      e = fq[d].pop_front();
      check_output({"frame_cnt", sfx}, cnt, e.cnt);
      check_output({"frame_err", sfx}, ferr, e.ferr);
      check_output({"line_err", sfx}, lerr, e.lerr);
      check_output({"writes_left", sfx}, wq[d].size(), 0);
    end
  endtask

  always @(negedge pclk) begin
    if (rst) begin
      if (ifa.mem_we) on_write(0, int'(ifa.mem_addr) * 256 + int'(ifa.mem_data));
      if (ifb.mem_we) on_write(1, int'(ifb.mem_addr) * 256 + int'(ifb.mem_data));
      if (fd_a) on_frame(0, int'(fcnt_a), ferr_a, lerr_a);
      if (fd_b) on_frame(1, int'(fcnt_b), ferr_b, lerr_b);
    end
  end

  initial begin
    exp_cnt    = 0;
    exp_lerr   = 1'b0;
    exp_ferr_a = 1'b0;
    exp_ferr_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_exp[d]  = 0;
      wr_seen[d] = 0;
    end

    repeat (3) @(posedge pclk);
    #1;
    check_zero("reset");
    rst    = 1'b1;
    enable = 1'b1;
    tick();
    vsync = 1'b1;
    repeat (4) tick();
    check_output("busy_wait_a", busy_a, 1);
    check_output("busy_wait_b", busy_b, 1);

    apply_stimulus(2, 0, 4, 1, 1'b1, 1'b0);
    apply_stimulus(4, 2, 4, 2, 1'b1, 1'b0);
    apply_stimulus(2, 3, 4, 0, 1'b1, 1'b0);
    apply_stimulus(3, 0, 5, 0, 1'b1, 1'b0);

    apply_stimulus(2, 1, 0, 0, 1'b1, 1'b1);
    repeat (2) tick();
    check_output("busy_drop_a", busy_a, 0);
    check_output("busy_drop_b", busy_b, 0);

    // Lines while waiting for vsync rise must not reach the frame buffer
    enable = 1'b1;
    tick();
    apply_stimulus(2, 0, 4, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++)
      apply_stimulus(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 0, 0, 1'b1, 1'b0);

    mode  = 2'b00;
    vsync = 1'b0;
    repeat (3) tick();
    href = 1'b1;
    din  = 8'hF8;
    tick();
    #2 rst = 1'b0;
    #1 check_zero("midreset");
    exp_cnt    = 0;
    exp_lerr   = 1'b0;
    exp_ferr_a = 1'b0;
    exp_ferr_b = 1'b0;
    repeat (4) begin
      din = 8'($urandom);
      tick();
    end
    rst = 1'b1;
    repeat (6) begin
      din = 8'($urandom);
      tick();
    end
    href = 1'b0;
    repeat (3) tick();
    vsync = 1'b1;
    repeat (4) tick();
    apply_stimulus(2, 0, 4, 1, 1'b1, 1'b0);

    repeat (5) tick();
    for (int d = 0; d < 2; d++) begin
      check_output(d == 0 ? "pending_writes_a" : "pending_writes_b", wq[d].size(), 0);
      check_output(d == 0 ? "pending_frames_a" : "pending_frames_b", fq[d].size(), 0);
      check_output(d == 0 ? "write_count_a" : "write_count_b", wr_seen[d], wr_exp[d]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cam_read_param.md
CAM_READ_PARAM -- requirements
Module: cam_read_param

Interface
REQ-001 Parameter H_RES, default 160: active pixels per camera line.
REQ-002 Parameter V_RES, default 120: active lines per camera frame.
REQ-003 Parameter DECIM, default 1: decimation factor, legal values 1 or 2; H_OUT=H_RES/DECIM, V_OUT=V_RES/DECIM.
REQ-004 Parameter ADDR_W, default 15: width of mem_addr; SHALL satisfy 2^ADDR_W >= H_OUT*V_OUT.
REQ-005 pclk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  capture enable, level.
REQ-008 mode  in  2  pixel format: 00 RGB565, 01 RGB444, 10 YUV422 gray, 11 raw byte.
REQ-009 vsync  in  1  camera frame sync, high between frames.
REQ-010 href  in  1  camera line valid.
REQ-011 input_data  in  8  camera byte bus.
REQ-012 mem_addr  out  ADDR_W  frame buffer write address.
REQ-013 mem_data  out  8  RGB332 or 8-bit gray pixel.
REQ-014 mem_we  out  1  one-cycle write strobe.
REQ-015 frame_done  out  1  one-cycle pulse at end of each captured frame.
REQ-016 busy  out  1  high while not in IDLE.
REQ-017 line_err  out  1  sticky: a line had more than H_RES pixels.
REQ-018 frame_err  out  1  sticky: a frame ended with line count != V_RES.
REQ-019 frame_cnt  out  8  completed frames, wraps 255->0.

Function
REQ-020 FSM states: IDLE, WAIT_VS (wait vsync rise), WAIT_ACT (wait vsync fall), CAPTURE.
REQ-021 IDLE->WAIT_VS when enable=1; WAIT_VS->WAIT_ACT on vsync 0->1 edge (registered previous vsync); WAIT_ACT->CAPTURE on vsync 1->0 edge.
REQ-022 CAPTURE on vsync rising edge: pulse frame_done, increment frame_cnt, evaluate frame_err; then ->WAIT_ACT if enable=1, else ->IDLE.
REQ-023 enable deasserted in CAPTURE SHALL NOT abort; frame completes first; deasserted in WAIT_VS/WAIT_ACT returns to IDLE next cycle.
REQ-024 Byte phase: cleared when href=0; toggles each href=1 cycle; phase0 byte latched, phase1 byte completes a pixel (modes 00-10); in mode 11 every href=1 byte is a pixel.
REQ-025 Conversion (b0 first byte, b1 second): 00 -> {b0[7:5],b0[2:0],b1[4:3]}; 01 -> {b0[3:1],b1[7:5],b1[3:2]}; 10 -> b0 (Y); 11 -> byte itself.
REQ-026 Pixel column counter and line counter reset at frame start; line counter increments on href 1->0 in CAPTURE.
REQ-027 With DECIM=2, only even columns of even lines written; DECIM=1 writes all.
REQ-028 Pixels with column >= H_RES SHALL NOT be written; line_err set.
REQ-029 Lines with index >= V_RES SHALL NOT be written.
REQ-030 mem_addr = (line/DECIM)*H_OUT + col/DECIM; mem_addr, mem_data, mem_we registered: valid the cycle after the edge that samples the completing byte.
REQ-031 frame_err set at frame end if line count != V_RES; line_err/frame_err clear only by reset.
REQ-032 Outside CAPTURE, href activity SHALL produce no writes.

Reset
REQ-033 rst=0 forces, immediately and regardless of pclk: state IDLE, mem_addr=0, mem_data=0, mem_we=0, frame_done=0, busy=0, line_err=0, frame_err=0, frame_cnt=0, all counters and byte phase 0.
REQ-034 Reset mid-frame discards the partial frame; next capture waits for a fresh vsync rise.

Verification
REQ-035 H_RES=4,V_RES=2,mode 00, bytes F8,1F per pixel -> 8 writes, addr 0..7, mem_data=E3, one frame_done, frame_cnt=1.
REQ-036 mode 10, bytes 55,80 repeated -> mem_data=55 every write; mode 11 -> one write per byte.
REQ-037 DECIM=2,H_RES=4,V_RES=4 -> 4 writes, addr 0..3, from lines 0,2 columns 0,2.
REQ-038 Line of 5 pixels with H_RES=4 -> 4 writes for that line, line_err=1; frame of 3 lines with V_RES=2 -> frame_err=1.
REQ-039 enable dropped mid-CAPTURE -> frame completes, frame_done pulses, busy falls next cycle; rst=0 mid-line -> outputs zero asynchronously, no further writes until new vsync rise/fall.
REQ-040 href toggling while in WAIT_VS -> mem_we stays 0.
